// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter that shares one SPI master port among NREQ requesters.
// The grant is held for a full request/response round trip, and a watchdog bounds the wait for the master.
module spi_master_arbiter #(
    parameter int NREQ    = 3,
    parameter int MSG_W   = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_val,
    output logic [NREQ-1:0]         req_rdy,
    input  logic [NREQ*MSG_W-1:0]   req_msg,
    output logic [NREQ-1:0]         resp_val,
    input  logic [NREQ-1:0]         resp_rdy,
    output logic [MSG_W-1:0]        resp_msg,
    output logic                    resp_err,
    output logic                    mst_req_val,
    input  logic                    mst_req_rdy,
    output logic [MSG_W-1:0]        mst_req_msg,
    input  logic                    mst_resp_val,
    output logic                    mst_resp_rdy,
    input  logic [MSG_W-1:0]        mst_resp_msg,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic [7:0]              drop_cnt
);
    localparam int ID_W  = $clog2(NREQ);
    localparam int SUM_W = ID_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DELIVER} state_e;

    state_e           state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [MSG_W-1:0] req_q, req_d;
    logic [MSG_W-1:0] resp_q, resp_d;
    logic             err_q, err_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic [7:0]       drop_q, drop_d;

    logic [ID_W-1:0]  sel;
    logic             sel_ok;
    logic [SUM_W-1:0] sum;

    // Scan ptr+1, ptr+2, ... wrapping modulo NREQ, which need not be a power of two.
    // NOTE: blocking assignments here are intentional; each loop pass reads the previous pass's sel_ok.
    always_comb begin
        sel    = '0;
        sel_ok = 1'b0;
        sum    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            sum = SUM_W'(ptr_q) + SUM_W'(k);
            if (sum >= SUM_W'(NREQ)) sum = sum - SUM_W'(NREQ);
            if (!sel_ok && req_val[sum[ID_W-1:0]]) begin
                sel_ok = 1'b1;
                sel    = sum[ID_W-1:0];
            end
        end
    end

    // NOTE: every signal starts from its held value, so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        req_d   = req_q;
        resp_d  = resp_q;
        err_d   = err_q;
        wdog_d  = wdog_q;
        drop_d  = drop_q;
        case (state_q)
            IDLE: begin
                if (mst_resp_val && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                if (sel_ok) begin
                    req_d   = req_msg[int'(sel)*MSG_W +: MSG_W];
                    grant_d = sel;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (mst_req_rdy) begin
                    wdog_d  = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                wdog_d = wdog_q + WD_W'(1);
                // A response on the final watchdog cycle still wins over the timeout.
                if (mst_resp_val) begin
                    resp_d  = mst_resp_msg;
                    err_d   = 1'b0;
                    state_d = DELIVER;
                end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    resp_d  = '0;
                    err_d   = 1'b1;
                    state_d = DELIVER;
                end
            end
            DELIVER: begin
                if (resp_rdy[grant_q]) begin
                    ptr_d   = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= ID_W'(NREQ - 1);
            grant_q <= '0;
            err_q   <= 1'b0;
            wdog_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            err_q   <= err_d;
            wdog_q  <= wdog_d;
            drop_q  <= drop_d;
        end
    end

    // NOTE: payload registers are not reset; the FSM never presents them before they are written.
    always_ff @(posedge clk) begin
        req_q  <= req_d;
        resp_q <= resp_d;
    end

    always_comb begin
        req_rdy      = '0;
        resp_val     = '0;
        resp_err     = 1'b0;
        mst_req_val  = 1'b0;
        mst_resp_rdy = 1'b0;
        case (state_q)
            IDLE: begin
                mst_resp_rdy = 1'b1;
                if (sel_ok) req_rdy = NREQ'(1) << sel;
            end
            SEND:    mst_req_val  = 1'b1;
            WAIT:    mst_resp_rdy = 1'b1;
            DELIVER: begin
                resp_val = NREQ'(1) << grant_q;
                resp_err = err_q;
            end
            default: ;
        endcase
    end

    assign resp_msg    = resp_q;
    assign mst_req_msg = req_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q != IDLE);
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Randomized bench for spi_master_arbiter: a transaction timeline model predicts every output each cycle.
// Each accepted request gets a schedule (accept, master handshake, delivery, release) computed by arithmetic.
module tb_spi_master_arbiter;
    localparam int NREQ    = 3;
    localparam int MSG_W   = 32;
    localparam int TIMEOUT = 8;
    localparam int ID_W    = $clog2(NREQ);

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req_val;
    logic [NREQ-1:0]        req_rdy;
    logic [NREQ*MSG_W-1:0]  req_msg;
    logic [NREQ-1:0]        resp_val;
    logic [NREQ-1:0]        resp_rdy;
    logic [MSG_W-1:0]       resp_msg;
    logic                   resp_err;
    logic                   mst_req_val;
    logic                   mst_req_rdy;
    logic [MSG_W-1:0]       mst_req_msg;
    logic                   mst_resp_val;
    logic                   mst_resp_rdy;
    logic [MSG_W-1:0]       mst_resp_msg;
    logic [ID_W-1:0]        grant_id;
    logic                   busy;
    logic [7:0]             drop_cnt;

    spi_master_arbiter #(.NREQ(NREQ), .MSG_W(MSG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_val      (req_val),
        .req_rdy      (req_rdy),
        .req_msg      (req_msg),
        .resp_val     (resp_val),
        .resp_rdy     (resp_rdy),
        .resp_msg     (resp_msg),
        .resp_err     (resp_err),
        .mst_req_val  (mst_req_val),
        .mst_req_rdy  (mst_req_rdy),
        .mst_req_msg  (mst_req_msg),
        .mst_resp_val (mst_resp_val),
        .mst_resp_rdy (mst_resp_rdy),
        .mst_resp_msg (mst_resp_msg),
        .grant_id     (grant_id),
        .busy         (busy),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Requesters and the model's view of the arbiter.
    int               cyc = 0;
    logic [NREQ-1:0]  pend = '0;
    logic [MSG_W-1:0] pdata [NREQ];
    bit               active = 0;
    int               g, a, h, d_cyc, t;
    logic [MSG_W-1:0] cur_msg, exp_resp, m_data;
    bit               exp_err;
    int               ptr = NREQ - 1;
    int               last_g = 0;
    int               drop_exp = 0;
    bit               m_pend = 0;
    int               m_start;

    // Stimulus knobs.
    int  raise_pct = 0;
    bit  force_p   = 0;
    int  f_mdel, f_j, f_rdel;
    int  rst_mil   = 0;
    bit  rst_now   = 0;
    bit  hold_reset = 0;

    function automatic int rr_pick(int p, logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return 0;
    endfunction

    // Plan a transaction accepted on cycle n from requester s.
    task automatic start_txn(int n, int s);
        int mdel, jj, rdel, r;
        g       = s;
        cur_msg = pdata[s];
        pend[s] = 1'b0;
        last_g  = s;
        a       = n;
        if (force_p) begin
            mdel = f_mdel; jj = f_j; rdel = f_rdel;
        end else begin
            mdel = int'($urandom_range(0, 5));
            r    = int'($urandom_range(0, 19));
            jj   = (r < 16) ? (r % 8) : (8 + r % 2);
            rdel = int'($urandom_range(0, 4));
        end
        h = a + 1 + mdel;
        if (jj < TIMEOUT) begin
            exp_err  = 1'b0;
            exp_resp = cur_msg + 1;
            d_cyc    = h + 2 + jj;
        end else begin
            exp_err  = 1'b1;
            exp_resp = '0;
            d_cyc    = h + 1 + TIMEOUT;
        end
        t       = d_cyc + rdel;
        m_pend  = 1'b1;
        m_start = h + 1 + jj;
        m_data  = cur_msg + 1;
        active  = 1'b1;
    endtask

    task automatic step();
        int n;
        bit do_rst;
        @(negedge clk);
        n = cyc;
        for (int i = 0; i < NREQ; i++)
            if (!pend[i] && int'($urandom_range(0, 99)) < raise_pct) begin
                pend[i]  = 1'b1;
                pdata[i] = $urandom;
            end
        req_val = pend;
        for (int i = 0; i < NREQ; i++) req_msg[i*MSG_W +: MSG_W] = pdata[i];
        mst_req_rdy  = (active && n > a && n <= h) ? (n == h) : 1'($urandom);
        mst_resp_val = m_pend && n >= m_start;
        mst_resp_msg = (m_pend && n >= m_start) ? m_data : $urandom;
        resp_rdy     = NREQ'($urandom);
        if (active && n >= d_cyc) resp_rdy[g] = (n >= t);
        do_rst = hold_reset;
        if (active && n > h && n < d_cyc && (rst_now || int'($urandom_range(0, 999)) < rst_mil)) begin
            do_rst  = 1'b1;
            rst_now = 1'b0;
        end
        reset = do_rst;
        #1;
        if (do_rst) begin
            active   = 1'b0;
            ptr      = NREQ - 1;
            last_g   = 0;
            drop_exp = 0;
            m_pend   = 1'b0;
        end else begin
            check("grant_id", grant_id, last_g);
            check("drop_cnt", drop_cnt, drop_exp);
            check("busy", busy, active);
            if (!active) begin
                check("idle_mst_req_val", mst_req_val, 0);
                check("idle_resp_val", resp_val, 0);
                check("idle_resp_err", resp_err, 0);
                check("idle_mst_resp_rdy", mst_resp_rdy, 1);
                if (m_pend && n >= m_start) begin
                    m_pend   = 1'b0;
                    drop_exp = (drop_exp == 255) ? 255 : drop_exp + 1;
                end
                if (pend != '0) begin
                    int s;
                    s = rr_pick(ptr, pend);
                    check("req_rdy_grant", req_rdy, NREQ'(1) << s);
                    start_txn(n, s);
                end else begin
                    check("req_rdy_none", req_rdy, 0);
                end
            end else begin
                check("busy_req_rdy", req_rdy, 0);
                if (n <= h) begin
                    check("send_mst_req_val", mst_req_val, 1);
                    check("send_mst_req_msg", mst_req_msg, cur_msg);
                    check("send_mst_resp_rdy", mst_resp_rdy, 0);
                    check("send_resp_val", resp_val, 0);
                end else if (n < d_cyc) begin
                    check("wait_mst_req_val", mst_req_val, 0);
                    check("wait_mst_resp_rdy", mst_resp_rdy, 1);
                    check("wait_resp_val", resp_val, 0);
                    if (!exp_err && n == m_start) m_pend = 1'b0;
                end else begin
                    check("dlv_mst_req_val", mst_req_val, 0);
                    check("dlv_mst_resp_rdy", mst_resp_rdy, 0);
                    check("dlv_resp_val", resp_val, NREQ'(1) << g);
                    check("dlv_resp_msg", resp_msg, exp_resp);
                    check("dlv_resp_err", resp_err, exp_err);
                    if (n == t) begin
                        active = 1'b0;
                        ptr    = g;
                    end
                end
            end
        end
        cyc++;
    endtask

    initial begin
        reset        = 1'b1;
        req_val      = '0;
        req_msg      = '0;
        resp_rdy     = '0;
        mst_req_rdy  = 1'b0;
        mst_resp_val = 1'b0;
        mst_resp_msg = '0;
        for (int i = 0; i < NREQ; i++) pdata[i] = '0;

        hold_reset = 1;
        repeat (3) step();
        hold_reset = 0;
        repeat (2) step();

        // Single transaction from requester 1, master echoes +1.
        force_p = 1; f_mdel = 0; f_j = 0; f_rdel = 0;
        pend[1] = 1'b1; pdata[1] = 32'hA5A5_0001;
        repeat (8) step();

        // All requesters held high: strict rotation.
        raise_pct = 100; f_j = 1;
        repeat (40) step();
        raise_pct = 0;
        repeat (20) step();

        // Timeout, then a late response dropped in IDLE, then a clean transaction.
        f_j = 8; pend = 3'b001; pdata[0] = $urandom;
        repeat (20) step();
        f_j = 9; f_rdel = 2; pend = 3'b010; pdata[1] = $urandom;
        repeat (20) step();
        f_j = 0; f_rdel = 0; pend = 3'b100; pdata[2] = $urandom;
        repeat (10) step();

        // Backpressure on both the master request and the response.
        f_mdel = 5; f_j = 1; f_rdel = 4; pend = 3'b010; pdata[1] = $urandom;
        repeat (20) step();

        // Master response on the last watchdog cycle.
        f_mdel = 0; f_j = TIMEOUT - 1; f_rdel = 0; pend = 3'b001; pdata[0] = $urandom;
        repeat (15) step();

        // Reset while waiting for the master.
        f_j = 5; raise_pct = 100; rst_now = 1;
        repeat (30) step();

        // Fully random traffic with occasional reset in WAIT.
        force_p = 0; raise_pct = 30; rst_mil = 5; rst_now = 0;
        repeat (3000) step();

        raise_pct = 0; rst_mil = 0;
        repeat (100) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
